// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - MEM-stage load/store request and response bundle
interface dmem_responder_if;
  logic        en;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic        req_fire;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        write_finish;
  logic        busy;

  modport master (
    output en, we, addr, wmask, wdata, req_fire,
    input  rdata, rdata_valid, write_finish, busy
  );

  modport slave (
    input  en, we, addr, wmask, wdata, req_fire,
    output rdata, rdata_valid, write_finish, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with fixed access latency
module dmem_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset,
  dmem_responder_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              we_q;
  logic [ADDR_W-1:0] idx_q;
  logic [3:0]        wmask_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              rdata_valid_q;
  logic              write_finish_q;
  logic              access;

  logic [31:0] mem [2**ADDR_W];

  // Byte offset and aliased upper address bits do not select a word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};

  assign access = (state == ST_WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= 4'd0;
      we_q           <= 1'b0;
      idx_q          <= '0;
      wmask_q        <= 4'd0;
      wdata_q        <= 32'd0;
      rdata_q        <= 32'd0;
      rdata_valid_q  <= 1'b0;
      write_finish_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.en) begin
            we_q    <= bus.we;
            idx_q   <= bus.addr[ADDR_W+1:2];
            wmask_q <= bus.wmask;
            wdata_q <= bus.wdata;
            cnt     <= CNT_INIT;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // en is deliberately ignored here: a captured store must always commit.
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (we_q) begin
              write_finish_q <= 1'b1;
            end else begin
              rdata_q       <= mem[idx_q];
              rdata_valid_q <= 1'b1;
            end
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Consumed, or MEM dropped en (pipeline flush): discard and return to idle.
          if (bus.req_fire || !bus.en) begin
            rdata_valid_q  <= 1'b0;
            write_finish_q <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Array is not reset; reset still blocks a store landing on the same edge.
  always_ff @(posedge clk) begin
    if (!reset && access && we_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign bus.rdata        = rdata_q;
  assign bus.rdata_valid  = rdata_valid_q;
  assign bus.write_finish = write_finish_q;
  assign bus.busy         = (state == ST_WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder at latencies 1 and 3
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if if1 ();
  dmem_responder_if if3 ();

  dmem_responder #(.ADDR_W(12), .LATENCY(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  dmem_responder #(.ADDR_W(12), .LATENCY(3)) u_dut3 (.clk(clk), .reset(reset), .bus(if3));

  // Index 0 drives the LATENCY=1 instance, index 1 the LATENCY=3 instance.
  logic        en_v    [2];
  logic        we_v    [2];
  logic [31:0] addr_v  [2];
  logic [3:0]  wmask_v [2];
  logic [31:0] wdata_v [2];
  logic        fire_v  [2];

  assign if1.en = en_v[0];  assign if1.we = we_v[0];  assign if1.addr = addr_v[0];
  assign if1.wmask = wmask_v[0];  assign if1.wdata = wdata_v[0];  assign if1.req_fire = fire_v[0];
  assign if3.en = en_v[1];  assign if3.we = we_v[1];  assign if3.addr = addr_v[1];
  assign if3.wmask = wmask_v[1];  assign if3.wdata = wdata_v[1];  assign if3.req_fire = fire_v[1];

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] mdl     [2][4096];
  logic [31:0] last_rd [2];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t tbl [6];

  function automatic logic [31:0] rd(input int sel);
    return (sel != 0) ? if3.rdata : if1.rdata;
  endfunction
  function automatic logic rv(input int sel);
    return (sel != 0) ? if3.rdata_valid : if1.rdata_valid;
  endfunction
  function automatic logic wf(input int sel);
    return (sel != 0) ? if3.write_finish : if1.write_finish;
  endfunction
  function automatic logic bz(input int sel);
    return (sel != 0) ? if3.busy : if1.busy;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input int sel, input logic we, input logic [31:0] addr,
                           input logic [3:0] wmask, input logic [31:0] wdata);
    en_v[sel] = 1'b1;  we_v[sel] = we;  addr_v[sel] = addr;
    wmask_v[sel] = wmask;  wdata_v[sel] = wdata;  fire_v[sel] = 1'b0;
  endtask

  // One full request: capture, latency, optional backpressure, consumption; model updated.
  task automatic txn(input int sel, input logic we, input logic [31:0] addr, input logic [3:0] wmask,
                     input logic [31:0] wdata, input int hold, output logic [31:0] rd_out);
    int n;
    logic seen;
    logic [31:0] held;
    int idx;
    int lat;
    lat = (sel != 0) ? 3 : 1;
    idx = int'((addr >> 2) & 32'hFFF);
    @(negedge clk);
    drive_req(sel, we, addr, wmask, wdata);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (rv(sel) || wf(sel)) seen = 1'b1;
      else check("busy_in_wait", bz(sel), 1'b1);
    end
    check("latency", n - 1, lat);
    check("resp_kind", {rv(sel), wf(sel)}, we ? 2'b01 : 2'b10);
    check("busy_in_resp", bz(sel), 1'b0);
    held = rd(sel);
    // Inputs wander after capture; they must not matter.
    addr_v[sel] = $urandom;  wdata_v[sel] = $urandom;  we_v[sel] = ~we;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_flag", rv(sel) | wf(sel), 1'b1);
      check("hold_rdata", rd(sel), held);
    end
    fire_v[sel] = 1'b1;
    @(negedge clk);
    fire_v[sel] = 1'b0;
    en_v[sel] = 1'b0;
    check("consume_clear", {rv(sel), wf(sel), bz(sel)}, 3'b000);
    rd_out = held;
    if (we) begin
      for (int i = 0; i < 4; i++)
        if (wmask[i]) mdl[sel][idx][8*i +: 8] = wdata[8*i +: 8];
      check("store_keeps_rdata", held, last_rd[sel]);
    end else begin
      check("load_data", held, mdl[sel][idx]);
      last_rd[sel] = mdl[sel][idx];
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int n;
    logic [31:0] a;
    logic [3:0] idx;

    for (int s = 0; s < 2; s++) begin
      en_v[s] = 0; we_v[s] = 0; addr_v[s] = 0; wmask_v[s] = 0; wdata_v[s] = 0; fire_v[s] = 0;
      last_rd[s] = 32'd0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      check("reset_rdata", rd(s), 32'd0);
      check("reset_flags", {rv(s), wf(s), bz(s)}, 3'b000);
    end

    tbl[0] = '{1'b1, 32'h0000_0010, 4'b1111, 32'hDEADBEEF, 32'h0000_0000};
    tbl[1] = '{1'b0, 32'h0000_0010, 4'b0000, 32'h0000_0000, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 32'h0000_0012, 4'b0010, 32'h11223344, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 32'h0000_0010, 4'b0000, 32'h0000_0000, 32'hDEAD33EF};
    tbl[4] = '{1'b1, 32'hFFFF_C010, 4'b0000, 32'h12345678, 32'hDEAD33EF};
    tbl[5] = '{1'b0, 32'h0000_4011, 4'b0000, 32'h0000_0000, 32'hDEAD33EF};
    for (int i = 0; i < 6; i++) begin
      txn(0, tbl[i].we, tbl[i].addr, tbl[i].wmask, tbl[i].wdata, 0, r);
      check("table_rdata", r, tbl[i].exp_rdata);
    end

    // Backpressure: response held five cycles before consumption.
    txn(0, 1'b0, 32'h10, 4'b0, 32'h0, 5, r);
    check("backpressure_rdata", r, 32'hDEAD33EF);

    // Latency-3 load through the slow instance.
    txn(1, 1'b1, 32'h10, 4'b1111, 32'hA5A5_0F0F, 0, r);
    txn(1, 1'b0, 32'h10, 4'b0000, 32'h0, 2, r);
    check("lat3_load", r, 32'hA5A5_0F0F);

    // Flush a load response in RESP.
    @(negedge clk);
    drive_req(0, 1'b0, 32'h10, 4'b0, 32'h0);
    n = 0;
    while (!rv(0) && n < 20) begin @(negedge clk); n++; end
    check("flush_seen", rv(0), 1'b1);
    en_v[0] = 1'b0;
    @(negedge clk);
    check("flush_clear", {rv(0), wf(0), bz(0)}, 3'b000);
    check("flush_rdata", rd(0), 32'hDEAD33EF);
    last_rd[0] = 32'hDEAD33EF;

    // Drop en during WAIT of a store: the store still commits.
    @(negedge clk);
    drive_req(1, 1'b1, 32'h40, 4'b1111, 32'hCAFEF00D);
    @(negedge clk);
    en_v[1] = 1'b0;
    repeat (5) @(negedge clk);
    check("wait_flush_idle", {rv(1), wf(1), bz(1)}, 3'b000);
    mdl[1][16] = 32'hCAFEF00D;
    txn(1, 1'b0, 32'h40, 4'b0, 32'h0, 0, r);
    check("wait_flush_commit", r, 32'hCAFEF00D);

    // Reset landing on the access edge of a pending store.
    txn(1, 1'b1, 32'h20, 4'b1111, 32'h55AA55AA, 0, r);
    @(negedge clk);
    drive_req(1, 1'b1, 32'h20, 4'b1111, 32'h0BADF00D);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    en_v[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_rdata", rd(1), 32'd0);
    check("midreset_flags", {rv(1), wf(1), bz(1)}, 3'b000);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    txn(1, 1'b0, 32'h20, 4'b0, 32'h0, 0, r);
    check("midreset_no_commit", r, 32'h55AA55AA);

    // Randomized traffic over 16 words with aliased upper and byte-offset bits.
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 16; w++)
        txn(s, 1'b1, 32'(w) << 2, 4'b1111, $urandom, 0, r);
      for (int k = 0; k < 30; k++) begin
        idx = 4'($urandom_range(0, 15));
        a = ($urandom & 32'hFFFF_C003) | (32'(idx) << 2);
        txn(s, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 3), r);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
